// File: rtl/lvds_tx_arbiter.sv
// Round-robin arbiter and frame sequencer feeding the 32-bit LVDS serializer.
// Grants one requester word per frame, tracks serializer busy, enforces an inter-frame gap.
module lvds_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [31:0]           ser_data_o,
  output logic                  ser_start_o,
  input  logic                  ser_busy_i,
  output logic [2:0]            grant_id_o,
  output logic                  active_o,
  input  logic                  err_clr_i,
  output logic                  err_timeout_o,
  output logic [15:0]           frames_sent_o
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t          state;
  logic [2:0]      last;
  logic [7:0]      to_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [2:0]      win;
  logic            win_ok;
  logic [31:0]     win_data;
  logic            accept;

  // Search starts just after the previous owner, wrapping modulo N_REQ.
  always_comb begin : pick
    int unsigned idx;
    idx      = '0;
    win      = '0;
    win_ok   = 1'b0;
    win_data = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last) + k) % N_REQ;
      if (!win_ok && req_valid[idx]) begin
        win_ok   = 1'b1;
        win      = idx[2:0];
        win_data = req_data[32*idx +: 32];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && state == IDLE && !ser_busy_i && win_ok)
      req_ready = N_REQ'(1) << win;
  end

  assign accept   = |(req_valid & req_ready);
  assign active_o = reset && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      ser_data_o    <= '0;
      ser_start_o   <= 1'b0;
      grant_id_o    <= '0;
      err_timeout_o <= 1'b0;
      frames_sent_o <= '0;
      last          <= 3'(N_REQ-1);
      to_cnt        <= '0;
      gap_cnt       <= '0;
    end else begin
      // A timeout in the same cycle overrides the clear below.
      if (err_clr_i) err_timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ser_data_o  <= win_data;
            grant_id_o  <= win;
            last        <= win;
            ser_start_o <= 1'b1;
            to_cnt      <= '0;
            state       <= START;
          end
        end
        START: begin
          if (ser_busy_i) begin
            ser_start_o <= 1'b0;
            state       <= WAIT_DONE;
          end else if (to_cnt == 8'(START_TIMEOUT-1)) begin
            ser_start_o   <= 1'b0;
            err_timeout_o <= 1'b1;
            gap_cnt       <= '0;
            state         <= GAP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!ser_busy_i) begin
            frames_sent_o <= frames_sent_o + 16'd1;
            gap_cnt       <= '0;
            state         <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES-1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
